// File: rtl/sram_arbiter_pkg.sv
// Shared SRAM geometry, default timing parameters and FSM state encoding
// for the camera/UART SRAM arbiter.
package sram_arbiter_pkg;

  localparam int SRAM_AW      = 18;
  localparam int SRAM_DW      = 16;
  localparam int WR_PULSE_DEF = 2;
  localparam int RD_WAIT_DEF  = 2;
  localparam int STARVE_DEF   = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_W_SETUP  = 3'd1,
    ST_W_PULSE  = 3'd2,
    ST_W_HOLD   = 3'd3,
    ST_R_ACCESS = 3'd4
  } arb_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sram_arbiter.sv
// Shares the single async SRAM (bank 1) between the capture write port and the
// UART read port; sequences CE/OE/WE with setup/hold and a turnaround idle.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int WR_PULSE_CYC = WR_PULSE_DEF,
  parameter int RD_WAIT_CYC  = RD_WAIT_DEF,
  parameter int STARVE_MAX   = STARVE_DEF
) (
  input  logic               sramClk,
  input  logic               sramRst,
  input  logic               wrReq,
  input  logic [SRAM_AW-1:0] wrAddr,
  input  logic [SRAM_DW-1:0] wrData,
  output logic               wrAck,
  input  logic               rdReq,
  input  logic [SRAM_AW-1:0] rdAddr,
  output logic               rdValid,
  output logic [SRAM_DW-1:0] rdData,
  output logic [SRAM_AW-1:0] SRADDR,
  output logic               SROE_N,
  output logic               SRWE_N,
  output logic               SRCE1_N,
  output logic               SRCE2_N,
  inout  wire  [SRAM_DW-1:0] SRDATA1
);

  localparam int PH_W = $clog2(max_int(WR_PULSE_CYC, RD_WAIT_CYC) + 1);
  localparam int SC_W = $clog2(STARVE_MAX + 1);

  localparam logic [PH_W-1:0] PH_ONE     = PH_W'(1);
  localparam logic [PH_W-1:0] WR_PH_LOAD = PH_W'(WR_PULSE_CYC - 1);
  localparam logic [PH_W-1:0] RD_PH_LOAD = PH_W'(RD_WAIT_CYC - 1);
  localparam logic [SC_W-1:0] SC_ONE     = SC_W'(1);
  localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);

  arb_state_e         state_r;
  logic [PH_W-1:0]    phase_r;
  logic [SC_W-1:0]    starve_cnt_r;
  logic               drv_en_r;
  logic [SRAM_DW-1:0] drv_data_r;
  logic               grant_wr_s;
  logic               grant_rd_s;

  // Arbitration on the request levels sampled at the edge leaving IDLE
  always_comb begin
    grant_wr_s = 1'b0;
    grant_rd_s = 1'b0;
    if (wrReq && rdReq) begin
      if (starve_cnt_r == STARVE_LIM) begin
        grant_rd_s = 1'b1;
      end else begin
        grant_wr_s = 1'b1;
      end
    end else if (wrReq) begin
      grant_wr_s = 1'b1;
    end else if (rdReq) begin
      grant_rd_s = 1'b1;
    end else begin
      grant_wr_s = 1'b0;
      grant_rd_s = 1'b0;
    end
  end

  // Access sequencer: state, phase counter and every SRAM/handshake output
  always_ff @(posedge sramClk) begin
    if (sramRst) begin
      state_r    <= ST_IDLE;
      phase_r    <= '0;
      SRADDR     <= '0;
      SROE_N     <= 1'b1;
      SRWE_N     <= 1'b1;
      SRCE1_N    <= 1'b1;
      drv_en_r   <= 1'b0;
      drv_data_r <= '0;
      wrAck      <= 1'b0;
      rdValid    <= 1'b0;
      rdData     <= '0;
    end else begin
      wrAck   <= 1'b0;
      rdValid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (grant_wr_s) begin
            state_r    <= ST_W_SETUP;
            SRADDR     <= wrAddr;
            drv_data_r <= wrData;
            drv_en_r   <= 1'b1;
            SRCE1_N    <= 1'b0;
          end else if (grant_rd_s) begin
            state_r <= ST_R_ACCESS;
            SRADDR  <= rdAddr;
            SRCE1_N <= 1'b0;
            SROE_N  <= 1'b0;
            phase_r <= RD_PH_LOAD;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_W_SETUP: begin
          state_r <= ST_W_PULSE;
          SRWE_N  <= 1'b0;
          phase_r <= WR_PH_LOAD;
        end
        ST_W_PULSE: begin
          if (phase_r == '0) begin
            state_r <= ST_W_HOLD;
            SRWE_N  <= 1'b1;
            wrAck   <= 1'b1;
          end else begin
            phase_r <= phase_r - PH_ONE;
          end
        end
        // Data stays driven through hold; bus released on return to IDLE
        ST_W_HOLD: begin
          state_r  <= ST_IDLE;
          drv_en_r <= 1'b0;
          SRCE1_N  <= 1'b1;
        end
        ST_R_ACCESS: begin
          if (phase_r == '0) begin
            state_r <= ST_IDLE;
            rdData  <= SRDATA1;
            rdValid <= 1'b1;
            SROE_N  <= 1'b1;
            SRCE1_N <= 1'b1;
          end else begin
            phase_r <= phase_r - PH_ONE;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          SROE_N   <= 1'b1;
          SRWE_N   <= 1'b1;
          SRCE1_N  <= 1'b1;
          drv_en_r <= 1'b0;
        end
      endcase
    end
  end

  // Counts write grants made while a read waits; forces a read at the limit
  always_ff @(posedge sramClk) begin
    if (sramRst) begin
      starve_cnt_r <= '0;
    end else if (!rdReq) begin
      starve_cnt_r <= '0;
    end else if ((state_r == ST_IDLE) && grant_rd_s) begin
      starve_cnt_r <= '0;
    end else if ((state_r == ST_IDLE) && grant_wr_s && (starve_cnt_r != STARVE_LIM)) begin
      starve_cnt_r <= starve_cnt_r + SC_ONE;
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  assign SRDATA1 = drv_en_r ? drv_data_r : {SRAM_DW{1'bz}};
  assign SRCE2_N = 1'b1;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: behavioural SRAM, strobe monitor and a
// transaction-level reference memory/arbitration model.
module tb_sram_arbiter;

  localparam int WR_PULSE = 2;
  localparam int RD_WAIT  = 2;
  localparam int STARVE   = 4;

  logic        sramClk = 1'b0;
  logic        sramRst;
  logic        wrReq, rdReq;
  logic [17:0] wrAddr, rdAddr;
  logic [15:0] wrData;
  logic        wrAck, rdValid;
  logic [15:0] rdData;
  logic [17:0] SRADDR;
  logic        SROE_N, SRWE_N, SRCE1_N, SRCE2_N;
  wire  [15:0] SRDATA1;

  sram_arbiter #(.WR_PULSE_CYC(WR_PULSE), .RD_WAIT_CYC(RD_WAIT), .STARVE_MAX(STARVE)) dut (
    .sramClk(sramClk), .sramRst(sramRst),
    .wrReq(wrReq), .wrAddr(wrAddr), .wrData(wrData), .wrAck(wrAck),
    .rdReq(rdReq), .rdAddr(rdAddr), .rdValid(rdValid), .rdData(rdData),
    .SRADDR(SRADDR), .SROE_N(SROE_N), .SRWE_N(SRWE_N),
    .SRCE1_N(SRCE1_N), .SRCE2_N(SRCE2_N), .SRDATA1(SRDATA1)
  );

  always #5 sramClk = ~sramClk;

  // Behavioural SRAM: reads drive the bus while CE/OE low, writes latch during WE low
  logic [15:0] sram_mem [0:262143];
  assign SRDATA1 = (!SRCE1_N && !SROE_N && SRWE_N) ? sram_mem[SRADDR] : 16'hzzzz;
  always @(posedge sramClk) if (!SRCE1_N && !SRWE_N) sram_mem[SRADDR] <= SRDATA1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model and monitor state
  logic [15:0] ref_mem [logic [17:0]];
  logic [15:0] exp_wr_data = 16'h0000;
  logic        mon_en = 1'b0;
  int          we_run = 0, oe_run = 0, gap_run = 1000;
  logic        ce_prev = 1'b1;
  int          we_len_q[$], oe_len_q[$], gap_q[$];
  bit          grant_q[$];
  int          wr_ack_cnt = 0, rd_valid_cnt = 0;

  always @(negedge sramClk) begin
    if (mon_en) begin
      chk("we_oe_overlap", {31'd0, SRWE_N | SROE_N}, 32'd1);
      chk("ce2_high", {31'd0, SRCE2_N}, 32'd1);
      if (!SRWE_N) chk("wr_bus_data", {16'd0, SRDATA1}, {16'd0, exp_wr_data});
      if (!SRWE_N) we_run++;
      else if (we_run != 0) begin we_len_q.push_back(we_run); we_run = 0; end
      if (!SROE_N) oe_run++;
      else if (oe_run != 0) begin oe_len_q.push_back(oe_run); oe_run = 0; end
      if (SRCE1_N) gap_run++;
      else begin
        if (ce_prev) begin gap_q.push_back(gap_run); grant_q.push_back(!SROE_N); end
        gap_run = 0;
      end
      ce_prev = SRCE1_N;
      if (wrAck) wr_ack_cnt++;
      if (rdValid) rd_valid_cnt++;
    end
  end

  task automatic do_write(input logic [17:0] a, input logic [15:0] d, output int lat);
    wrAddr = a; wrData = d; exp_wr_data = d; wrReq = 1'b1; lat = 0;
    while (lat < 30) begin
      @(posedge sramClk); #1; lat++;
      if (wrAck) break;
    end
    wrReq = 1'b0;
    chk("wr_ack_seen", {31'd0, wrAck}, 32'd1);
    ref_mem[a] = d;
    @(posedge sramClk); #1;
  endtask

  task automatic do_read(input logic [17:0] a, output int lat, output logic [15:0] q);
    rdAddr = a; rdReq = 1'b1; lat = 0;
    while (lat < 30) begin
      @(posedge sramClk); #1; lat++;
      if (rdValid) break;
    end
    rdReq = 1'b0;
    chk("rd_valid_seen", {31'd0, rdValid}, 32'd1);
    q = rdData;
    @(posedge sramClk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, acks0, cyc;
    logic [15:0] q, d;
    logic [17:0] pool [6];

    sramRst = 1'b1; wrReq = 1'b0; rdReq = 1'b0;
    wrAddr = '0; rdAddr = '0; wrData = '0;
    repeat (3) @(posedge sramClk);
    #1;
    chk("rst_addr", {14'd0, SRADDR}, 32'd0);
    chk("rst_strobes", {29'd0, SROE_N, SRWE_N, SRCE1_N}, 32'd7);
    chk("rst_ce2", {31'd0, SRCE2_N}, 32'd1);
    chk("rst_acks", {30'd0, wrAck, rdValid}, 32'd0);
    chk("rst_rddata", {16'd0, rdData}, 32'd0);
    sramRst = 1'b0; mon_en = 1'b1;
    @(posedge sramClk); #1;

    // Single write then read of the same word
    acks0 = wr_ack_cnt;
    do_write(18'h00010, 16'hBEEF, lat);
    chk("wr_latency", 32'(lat), 32'(2 + WR_PULSE));
    chk("we_low_len", 32'(we_len_q[we_len_q.size()-1]), 32'(WR_PULSE));
    chk("wr_ack_once", 32'(wr_ack_cnt - acks0), 32'd1);
    chk("model_holds", {16'd0, sram_mem[18'h00010]}, 32'h0000BEEF);
    do_read(18'h00010, lat, q);
    chk("rd_latency", 32'(lat), 32'(RD_WAIT + 1));
    chk("oe_low_len", 32'(oe_len_q[oe_len_q.size()-1]), 32'(RD_WAIT));
    chk("rd_data_beef", {16'd0, q}, 32'h0000BEEF);

    // Write immediately followed by a read request: exactly one idle turnaround
    gap_q.delete(); grant_q.delete();
    wrAddr = 18'h00020; wrData = 16'h5A5A; exp_wr_data = 16'h5A5A; wrReq = 1'b1;
    cyc = 0;
    while (cyc < 30 && !wrAck) begin @(posedge sramClk); #1; cyc++; end
    wrReq = 1'b0; ref_mem[18'h00020] = 16'h5A5A;
    rdAddr = 18'h00020; rdReq = 1'b1;
    cyc = 0;
    while (cyc < 30 && !rdValid) begin @(posedge sramClk); #1; cyc++; end
    rdReq = 1'b0;
    chk("wr_rd_valid", {31'd0, rdValid}, 32'd1);
    chk("wr_rd_data", {16'd0, rdData}, 32'h00005A5A);
    chk("wr_rd_grants", 32'(grant_q.size()), 32'd2);
    chk("wr_rd_is_read", {31'd0, grant_q[grant_q.size()-1]}, 32'd1);
    chk("turnaround_gap", 32'(gap_q[gap_q.size()-1]), 32'd1);
    @(posedge sramClk); #1;

    // Both requesters held high: writes may starve a read at most STARVE times
    grant_q.delete();
    rdAddr = 18'h00010; wrAddr = 18'h00030; wrData = 16'h7777; exp_wr_data = 16'h7777;
    wrReq = 1'b1; rdReq = 1'b1;
    cyc = 0;
    while (cyc < 400 && grant_q.size() < 15) begin
      @(posedge sramClk); #1; cyc++;
      if (rdValid) chk("starve_rd_data", {16'd0, rdData}, {16'd0, ref_mem[18'h00010]});
    end
    wrReq = 1'b0; rdReq = 1'b0; ref_mem[18'h00030] = 16'h7777;
    repeat (10) @(posedge sramClk);
    #1;
    chk("starve_grant_cnt", {31'd0, grant_q.size() >= 15}, 32'd1);
    for (int k = 0; k < 15; k++)
      chk($sformatf("grant_order_%0d", k), {31'd0, grant_q[k]}, {31'd0, (k % (STARVE + 1)) == STARVE});

    // Randomized traffic against the reference memory
    pool[0] = 18'h00000; pool[1] = 18'h3FFFE; pool[2] = 18'h00100;
    pool[3] = 18'h1ABCD; pool[4] = 18'h2F00F; pool[5] = 18'h00011;
    for (int i = 0; i < 6; i++) begin
      d = 16'($urandom);
      do_write(pool[i], d, lat);
      chk("rnd_init_lat", 32'(lat), 32'(2 + WR_PULSE));
    end
    for (int i = 0; i < 30; i++) begin
      int idx;
      idx = $urandom_range(0, 5);
      if ($urandom_range(0, 1) == 1) begin
        d = 16'($urandom);
        do_write(pool[idx], d, lat);
        chk("rnd_wr_lat", 32'(lat), 32'(2 + WR_PULSE));
        chk("rnd_we_len", 32'(we_len_q[we_len_q.size()-1]), 32'(WR_PULSE));
        chk("rnd_rd_hold", {16'd0, rdData}, {16'd0, q});
      end else begin
        do_read(pool[idx], lat, q);
        chk("rnd_rd_lat", 32'(lat), 32'(RD_WAIT + 1));
        chk("rnd_rd_data", {16'd0, q}, {16'd0, ref_mem[pool[idx]]});
      end
      repeat ($urandom_range(0, 2)) @(posedge sramClk);
      #0;
    end

    // Reset in the middle of the write pulse aborts the access
    acks0 = wr_ack_cnt;
    wrAddr = 18'h00200; wrData = 16'hDEAD; exp_wr_data = 16'hDEAD; wrReq = 1'b1;
    cyc = 0;
    while (cyc < 10 && SRWE_N) begin @(posedge sramClk); #1; cyc++; end
    chk("abort_we_low", {31'd0, SRWE_N}, 32'd0);
    sramRst = 1'b1; wrReq = 1'b0;
    @(posedge sramClk); #1;
    chk("abort_strobes", {29'd0, SROE_N, SRWE_N, SRCE1_N}, 32'd7);
    chk("abort_acks", {30'd0, wrAck, rdValid}, 32'd0);
    sramRst = 1'b0;
    repeat (6) @(posedge sramClk);
    #1;
    chk("abort_no_ack", 32'(wr_ack_cnt - acks0), 32'd0);
    chk("abort_idle_ce", {31'd0, SRCE1_N}, 32'd1);

    // Top-of-range address round trip
    do_write(18'h3FFFF, 16'h1234, lat);
    chk("top_wr_lat", 32'(lat), 32'(2 + WR_PULSE));
    do_read(18'h3FFFF, lat, q);
    chk("top_rd_data", {16'd0, q}, 32'h00001234);
    chk("top_rd_lat", 32'(lat), 32'(RD_WAIT + 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
